// File: rtl/cmp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nslice);
    return (clog2(nslice) > 1) ? clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/compare_slice.sv
// One SLICE-bit step of an MSB-first eq/lt chain; purely combinational.
// msb_signed flips the sign bit so two's complement orders like unsigned.
module compare_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             msb_signed,
  output logic             eq_out,
  output logic             lt_out
);

  logic [SLICE-1:0] flip;
  logic [SLICE-1:0] a_m;
  logic [SLICE-1:0] b_m;
  logic             seq;
  logic             slt;

  assign flip   = SLICE'(msb_signed) << (SLICE - 1);
  assign a_m    = a ^ flip;
  assign b_m    = b ^ flip;
  assign seq    = (a == b);
  assign slt    = (a_m < b_m);
  assign eq_out = eq_in & seq;
  assign lt_out = lt_in | (eq_in & slt);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning one SLICE per clock, MSB first.
// start/done handshake; results held in EQ/LT/GT until the next done or reset.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             LT,
  output logic             GT
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  generate
    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
      $error("seq_magnitude_comparator: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             eq_acc_q, eq_acc_d;
  logic             lt_acc_q, lt_acc_d;
  logic             done_q, done_d;
  logic             eq_res_q, eq_res_d;
  logic             lt_res_q, lt_res_d;
  logic             gt_res_q, gt_res_d;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic             msb_signed;
  logic             eq_n;
  logic             lt_n;
  logic             last;

  assign a_sl       = a_q[int'(idx_q) * SLICE +: SLICE];
  assign b_sl       = b_q[int'(idx_q) * SLICE +: SLICE];
  assign msb_signed = sgn_q && (idx_q == IDX_TOP);

  compare_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a          (a_sl),
    .b          (b_sl),
    .eq_in      (eq_acc_q),
    .lt_in      (lt_acc_q),
    .msb_signed (msb_signed),
    .eq_out     (eq_n),
    .lt_out     (lt_n)
  );

  // Once eq clears, later slices cannot change the verdict, so early exit is safe.
  assign last = (idx_q == '0) || (EARLY_EXIT && !eq_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    EQ   = eq_res_q;
    LT   = lt_res_q;
    GT   = gt_res_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    idx_d    = idx_q;
    eq_acc_d = eq_acc_q;
    lt_acc_d = lt_acc_q;
    done_d   = 1'b0;
    eq_res_d = eq_res_q;
    lt_res_d = lt_res_q;
    gt_res_d = gt_res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          sgn_d    = is_signed;
          idx_d    = IDX_TOP;
          eq_acc_d = 1'b1;
          lt_acc_d = 1'b0;
        end
      end
      RUN: begin
        if (last) begin
          eq_res_d = eq_n;
          lt_res_d = lt_n;
          gt_res_d = ~eq_n & ~lt_n;
          done_d   = 1'b1;
        end else begin
          eq_acc_d = eq_n;
          lt_acc_d = lt_n;
          idx_d    = idx_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      idx_q    <= '0;
      eq_acc_q <= 1'b0;
      lt_acc_q <= 1'b0;
      done_q   <= 1'b0;
      eq_res_q <= 1'b0;
      lt_res_q <= 1'b0;
      gt_res_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      idx_q    <= idx_d;
      eq_acc_q <= eq_acc_d;
      lt_acc_q <= lt_acc_d;
      done_q   <= done_d;
      eq_res_q <= eq_res_d;
      lt_res_q <= lt_res_d;
      gt_res_q <= gt_res_d;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboarded bench: one early-exit and one fixed-latency instance, WIDTH=8, SLICE=2.
module tb_seq_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_ee, start_fx;
  logic [7:0] a, b;
  logic       sgn;
  logic       sel;
  logic       busy_ee, done_ee, eq_ee, lt_ee, gt_ee;
  logic       busy_fx, done_fx, eq_fx, lt_fx, gt_fx;
  logic       busy_s, done_s, eq_s, lt_s, gt_s;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       eq;
    logic       lt;
    logic       gt;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(8), .SLICE(2), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .start(start_ee), .A(a), .B(b), .is_signed(sgn),
    .busy(busy_ee), .done(done_ee), .EQ(eq_ee), .LT(lt_ee), .GT(gt_ee)
  );

  seq_magnitude_comparator #(.WIDTH(8), .SLICE(2), .EARLY_EXIT(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .start(start_fx), .A(a), .B(b), .is_signed(sgn),
    .busy(busy_fx), .done(done_fx), .EQ(eq_fx), .LT(lt_fx), .GT(gt_fx)
  );

  assign busy_s = sel ? busy_fx : busy_ee;
  assign done_s = sel ? done_fx : done_ee;
  assign eq_s   = sel ? eq_fx   : eq_ee;
  assign lt_s   = sel ? lt_fx   : lt_ee;
  assign gt_s   = sel ? gt_fx   : gt_ee;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic s, input logic ee);
    exp_t e;
    logic found;
    e.eq  = (x == y);
    e.lt  = s ? ($signed(x) < $signed(y)) : (x < y);
    e.gt  = !e.eq && !e.lt;
    e.lat = 8'd4;
    found = 1'b0;
    if (ee) begin
      for (int i = 3; i >= 0; i--) begin
        if (!found && (x[2*i +: 2] != y[2*i +: 2])) begin
          e.lat = 8'(4 - i);
          found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic issue(input logic fx, input logic [7:0] x, input logic [7:0] y, input logic s);
    @(negedge clk);
    sel = fx;
    a   = x;
    b   = y;
    sgn = s;
    if (fx) start_fx = 1'b1;
    else    start_ee = 1'b1;
    sb.push_back(model(x, y, s, !fx));
    @(posedge clk);
    #1;
    start_ee = 1'b0;
    start_fx = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = done_s;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_ee = 1'b0; start_fx = 1'b0; sel = 1'b0;
    a = '0; b = '0; sgn = 1'b0;
    #3;
    n_total++; if (busy_s !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_s); else n_pass++;
    n_total++; if (done_s !== 1'b0) $display("FAIL reset_done got %b want 0", done_s); else n_pass++;
    n_total++; if (eq_s !== 1'b0) $display("FAIL reset_eq got %b want 0", eq_s); else n_pass++;
    n_total++; if (lt_s !== 1'b0) $display("FAIL reset_lt got %b want 0", lt_s); else n_pass++;
    n_total++; if (gt_s !== 1'b0) $display("FAIL reset_gt got %b want 0", gt_s); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({busy_ee, busy_fx, done_ee, done_fx} !== 4'b0)
      $display("FAIL idle_after_reset got %b want 0000", {busy_ee, busy_fx, done_ee, done_fx});
    else n_pass++;
  endtask

  task automatic test_equal_full();
    int cyc; logic seen; exp_t e;
    issue(1'b0, 8'hA5, 8'hA5, 1'b0);
    n_total++; if (busy_s !== 1'b1) $display("FAIL eq_busy got %b want 1", busy_s); else n_pass++;
    wait_done(cyc, seen);
    e = sb.pop_front();
    n_total++;
    if ({seen, 8'(cyc), eq_s, lt_s, gt_s} !== {1'b1, e.lat, e.eq, e.lt, e.gt})
      $display("FAIL eq_full got seen=%b lat=%0d eq/lt/gt=%b%b%b want lat=%0d %b%b%b",
               seen, cyc, eq_s, lt_s, gt_s, e.lat, e.eq, e.lt, e.gt);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({done_s, busy_s, eq_s} !== 3'b001)
      $display("FAIL done_pulse got done/busy/eq=%b want 001", {done_s, busy_s, eq_s});
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [24:0] tbl [9];
    int cyc; logic seen; exp_t e;
    tbl[0] = {1'b0, 8'h12, 8'hC0, 1'b0, 7'd0};
    tbl[1] = {1'b1, 8'h12, 8'hC0, 1'b0, 7'd0};
    tbl[2] = {1'b0, 8'h35, 8'h36, 1'b0, 7'd0};
    tbl[3] = {1'b0, 8'h36, 8'h35, 1'b0, 7'd0};
    tbl[4] = {1'b0, 8'h80, 8'h7F, 1'b1, 7'd0};
    tbl[5] = {1'b0, 8'h80, 8'h7F, 1'b0, 7'd0};
    tbl[6] = {1'b0, 8'hFF, 8'hFE, 1'b1, 7'd0};
    tbl[7] = {1'b1, 8'h80, 8'h7F, 1'b1, 7'd0};
    tbl[8] = {1'b0, 8'h7F, 8'h80, 1'b1, 7'd0};
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i][24], tbl[i][23:16], tbl[i][15:8], tbl[i][7]);
      wait_done(cyc, seen);
      e = sb.pop_front();
      n_total++;
      if ({seen, 8'(cyc), eq_s, lt_s, gt_s} !== {1'b1, e.lat, e.eq, e.lt, e.gt})
        $display("FAIL vector%0d got seen=%b lat=%0d eq/lt/gt=%b%b%b want lat=%0d %b%b%b",
                 i, seen, cyc, eq_s, lt_s, gt_s, e.lat, e.eq, e.lt, e.gt);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int cyc; logic seen; exp_t e;
    logic [7:0] x, y;
    for (int i = 0; i < 12; i++) begin
      x = 8'($urandom_range(0, 255));
      y = (i % 4 == 0) ? x : 8'($urandom_range(0, 255));
      issue(1'(i % 2), x, y, 1'($urandom_range(0, 1)));
      wait_done(cyc, seen);
      e = sb.pop_front();
      n_total++;
      if ({seen, 8'(cyc), eq_s, lt_s, gt_s} !== {1'b1, e.lat, e.eq, e.lt, e.gt})
        $display("FAIL random%0d a=%h b=%h s=%b got seen=%b lat=%0d eq/lt/gt=%b%b%b want lat=%0d %b%b%b",
                 i, x, y, sgn, seen, cyc, eq_s, lt_s, gt_s, e.lat, e.eq, e.lt, e.gt);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic seen; exp_t e;
    issue(1'b1, 8'h10, 8'h20, 1'b0);
    // New operands and a held start while busy: must not disturb the compare in flight.
    a = 8'h20; b = 8'h10; start_fx = 1'b1;
    wait_done(cyc, seen);
    e = sb.pop_front();
    n_total++;
    if ({seen, 8'(cyc), eq_s, lt_s, gt_s} !== {1'b1, e.lat, e.eq, e.lt, e.gt})
      $display("FAIL busy_ignore got seen=%b lat=%0d eq/lt/gt=%b%b%b want lat=%0d %b%b%b",
               seen, cyc, eq_s, lt_s, gt_s, e.lat, e.eq, e.lt, e.gt);
    else n_pass++;
    n_total++; if (busy_s !== 1'b0) $display("FAIL busy_on_done got %b want 0", busy_s); else n_pass++;
    sb.push_back(model(8'h20, 8'h10, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    start_fx = 1'b0;
    n_total++;
    if ({busy_s, done_s} !== 2'b10)
      $display("FAIL accept_after_done got busy/done=%b want 10", {busy_s, done_s});
    else n_pass++;
    wait_done(cyc, seen);
    e = sb.pop_front();
    n_total++;
    if ({seen, 8'(cyc), eq_s, lt_s, gt_s} !== {1'b1, e.lat, e.eq, e.lt, e.gt})
      $display("FAIL held_start got seen=%b lat=%0d eq/lt/gt=%b%b%b want lat=%0d %b%b%b",
               seen, cyc, eq_s, lt_s, gt_s, e.lat, e.eq, e.lt, e.gt);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int cyc; logic seen; exp_t e;
    logic extra;
    issue(1'b0, 8'h01, 8'h01, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    n_total++;
    if ({busy_s, done_s, eq_s, lt_s, gt_s} !== 5'b0)
      $display("FAIL async_abort got busy/done/eq/lt/gt=%b want 00000", {busy_s, done_s, eq_s, lt_s, gt_s});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_s || busy_s) extra = 1'b1;
    end
    n_total++; if (extra !== 1'b0) $display("FAIL no_done_after_abort got %b want 0", extra); else n_pass++;
    issue(1'b0, 8'h01, 8'h01, 1'b0);
    wait_done(cyc, seen);
    e = sb.pop_front();
    n_total++;
    if ({seen, 8'(cyc), eq_s, lt_s, gt_s} !== {1'b1, e.lat, e.eq, e.lt, e.gt})
      $display("FAIL after_abort got seen=%b lat=%0d eq/lt/gt=%b%b%b want lat=%0d %b%b%b",
               seen, cyc, eq_s, lt_s, gt_s, e.lat, e.eq, e.lt, e.gt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_equal_full();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle magnitude comparator for WIDTH-bit operands. It scans the operands one SLICE-bit slice per clock, MSB slice first. Each step chains an eq/lt pair through a parametrised slice comparator. It generalises the fixed 2-bit compare slice with arbitrary width, a start/done handshake, optional early termination and a signed (two's complement) mode. It sits beside the ALU/datapath wherever a compare is needed and area matters more than latency.

Parameters:
WIDTH, 16, operand width in bits; must be a positive multiple of SLICE (elaboration error otherwise)
SLICE, 2, bits compared per clock; 1 <= SLICE <= WIDTH
EARLY_EXIT, 1, 1 = finish as soon as the running eq clears; 0 = always scan all slices (fixed latency)

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only on a rising edge where busy=0
A  input  WIDTH  operand A, sampled only on the accepting edge
B  input  WIDTH  operand B, sampled only on the accepting edge
is_signed  input  1  1 = two's complement compare, 0 = unsigned; sampled with A/B
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse, result valid
EQ  output  1  A == B
LT  output  1  A < B
GT  output  1  A > B

Behaviour:
- Interface: one clock, clk. Reset is rst, asynchronous and active-high. rst=1 forces state IDLE and sets busy=0, done=0, EQ=0, LT=0, GT=0, all immediately and independent of clk. Internal registers clear the same way.
- NSLICE = WIDTH/SLICE. Slice index register width = max(1, clog2(NSLICE)).
- States are IDLE and RUN.
- IDLE, start=1 on an edge:
  - latch A, B and is_signed
  - idx <= NSLICE-1, eq_acc <= 1, lt_acc <= 0
  - busy <= 1, go to RUN
- IDLE, start=0: no change. Outputs hold their last result.
- RUN, each edge, evaluating slice idx (bits [idx*SLICE+SLICE-1 : idx*SLICE]):
  - seq = (a_s == b_s); slt = (a_s < b_s), unsigned
  - eq_n = eq_acc & seq; lt_n = lt_acc | (eq_acc & slt)
  - Signed mode, MSB slice only (idx = NSLICE-1): invert the top bit of both a_s and b_s before computing slt.
- Exit condition: idx==0, or (EARLY_EXIT=1 and eq_n==0). On exit:
  - EQ <= eq_n, LT <= lt_n, GT <= ~eq_n & ~lt_n
  - done <= 1, busy <= 0, go to IDLE
- Otherwise: eq_acc <= eq_n, lt_acc <= lt_n, idx <= idx-1.
- Latency: done rises k edges after the accepting edge. k = NSLICE when EARLY_EXIT=0, or when all slices are equal. k = (position of the first unequal slice from the MSB) + 1 when EARLY_EXIT=1.
- done is high for exactly one cycle. The EQ/LT/GT triple is updated only on the done edge and held until the next done or rst.
- Exactly one of EQ/LT/GT is 1 after any done. All three are 0 only after reset.
- start while busy=1 is ignored. The in-flight operands are unaffected.
- start on the same edge that done is registered is ignored, because busy is still 1 on that edge. The earliest new accept is the following edge.
- rst mid-RUN aborts the compare. No done pulse follows.
- A/B/is_signed changing during RUN has no effect.

Decomposition:
- Package cmp_pkg: state enum (IDLE, RUN), clog2 helper function.
- Sub-module compare_slice, combinational and parametrised by SLICE:
  - inputs: a, b, eq_in, lt_in, msb_signed
  - outputs: eq_out, lt_out
  - implements the chaining equations above
- The top module holds the FSM, the operand registers, idx and the result registers, and instantiates one compare_slice.

Test Plan:
All scenarios use WIDTH=8, SLICE=2 (NSLICE=4).
1. EARLY_EXIT=1, unsigned, A=0xA5, B=0xA5, start one cycle -> busy for 4 edges; done pulse on the 4th edge; EQ=1, LT=0, GT=0.
2. EARLY_EXIT=1, A=0x12, B=0xC0 -> done after 1 edge, LT=1. Repeat with EARLY_EXIT=0 -> done after 4 edges, LT=1.
3. A=0x35, B=0x36, unsigned -> done after 4 edges, LT=1. Swap the operands -> GT=1.
4. A=0x80, B=0x7F: is_signed=1 -> LT=1 (-128 < 127); is_signed=0 -> GT=1. Also A=0xFF, B=0xFE signed -> GT=1.
5. Start A=0x10, B=0x20. Assert start with A=0x20, B=0x10 while busy=1 -> only one done pulse, LT=1. A start held high through done -> new accept on the edge after done.
6. rst=1 asynchronously during RUN (between edges) -> busy, done, EQ, LT, GT drop immediately; no later done. Then A=0x01, B=0x01 -> EQ=1 after 4 edges.
